tlb_pipe: RTL and testbench
===========================

Name: tlb_pipe

Overview:
Parametrised successor of the dual-port lookup TLB. It is fully associative with two registered search ports (1-cycle latency) and multi-hit detection. It adds a wired-aware random replacement index and a sequential flush engine that invalidates all entries or a single ASID. It sits between the IF/MEM stages and CP0 in the MIPS core and serves TLBP/TLBR/TLBWI/TLBWR.

Parameters:
TLB_NUM, 32, number of entries (power of 2, 4..64)
IDX_W, $clog2(TLB_NUM), entry index width
ASID_W, 8, ASID width
PFN_W, 20, physical frame number width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s0_req, s1_req  in  1  search request, one per port (port = 0/1; the port signals below repeat with s0_ and s1_ prefixes)
sN_vpn2  in  19  virtual page pair number
sN_odd_page  in  1  selects the odd half of the page pair
sN_asid  in  ASID_W  lookup ASID
sN_rvalid  out  1  result valid, one cycle after sN_req
sN_found  out  1  at least one entry hit
sN_multi  out  1  more than one entry hit
sN_index  out  IDX_W  lowest-numbered hitting entry
sN_pfn  out  PFN_W  selected PFN
sN_c  out  3  selected cache attribute
sN_d  out  1  selected dirty bit
sN_v  out  1  selected valid bit
wr  in  1  write strobe
w_index  in  IDX_W  write entry index
w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  in  19/ASID_W/1/PFN_W/3/1/1/PFN_W/3/1/1  entry fields
r_req  in  1  read request
r_index  in  IDX_W  read entry index
r_vpn2 .. r_v1  out  same widths as the w_ fields  read data, valid one cycle after r_req
wired  in  IDX_W  CP0 Wired value
rand_index  out  IDX_W  replacement index for TLBWR
flush_req  in  1  start flush (single-cycle pulse)
flush_all  in  1  1 = all entries, 0 = flush_asid only
flush_asid  in  ASID_W  ASID to flush
flush_busy  out  1  flush engine active
flush_done  out  1  one-cycle pulse when the flush completes

Behaviour:
- Reset (async, immediate): every entry is zeroed, with c0 = c1 = 3. All s*/r_ outputs = 0. rand_index = TLB_NUM-1. FSM = IDLE. flush_busy = flush_done = 0.
- Entry match: vpn2 equal, and (asid equal or g set).
- Search: sampled at the clk edge where sN_req = 1. Results are registered and valid the next cycle with sN_rvalid = 1.
- Search output hold: outputs hold their value until the next request; sN_rvalid is 0 in cycles with no request result.
- Search array state: the search sees array contents before any write or flush clear in the same edge. There is no write-to-search bypass.
- Search field selection: pfn/c/d/v come from the lowest-index hit, odd or even half per sN_odd_page.
- Search miss: found = 0, multi = 0, index = 0, pfn/c/d/v = 0.
- Read: registered, 1-cycle latency, outputs hold between requests. Same-edge write to r_index returns the old data.
- Write: when wr = 1, the entry at w_index is updated at the edge. Accepted in any FSM state.
- Random counter, decrement: decrements every cycle.
- Random counter, wrap: if rand_index <= wired, the next value is TLB_NUM-1.
- Random counter, large wired: if wired >= TLB_NUM-1, rand_index holds at TLB_NUM-1.
- Random counter, write: a write does not alter the counter.
- Flush FSM, IDLE: flush_req -> latch flush_all/flush_asid, ptr = 0, go to SWEEP, flush_busy = 1.
- Flush FSM, SWEEP: one entry per cycle at ptr.
  - If flush_all, or (tlb_asid[ptr] == latched asid and !g): clear v0 and v1.
  - ptr increments; after ptr = TLB_NUM-1 go to DONE.
- Flush FSM, DONE: flush_done = 1 for one cycle, flush_busy = 0, return to IDLE. A flush takes TLB_NUM+1 cycles from the flush_req edge to the done pulse.
- flush_req while not IDLE: ignored.
- Write and flush clear at the same index in the same cycle: the write wins (the entry takes the w_ fields).
- Searches and reads during a flush: allowed. They reflect entries cleared so far.
- Reset mid-flush: aborts immediately, no done pulse.

Test Plan:
- Reset release, then write index 5 (vpn2 = 0x12345, asid = 3, g = 0, pfn0 = 0xAAAAA, v0 = 1, pfn1 = 0xBBBBB, v1 = 0), then s0 search vpn2 = 0x12345, asid = 3, odd = 0 -> next cycle: rvalid = 1, found = 1, index = 5, pfn = 0xAAAAA, v = 1. Same search with odd = 1 -> pfn = 0xBBBBB, v = 0.
- Write identical vpn2/asid to entries 2 and 9, then search on both ports in the same cycle -> both: found = 1, multi = 1, index = 2.
- Search asid = 4 against the entry above -> found = 0. Rewrite that entry with g = 1 -> found = 1.
- wired = 30 with TLB_NUM = 32: rand_index runs 31, 30, 31, 30, ... Set wired = 0: sequence 31 .. 1, 0, 31. Set wired = 31: holds at 31.
- Fill entries 0..3 with asid 1/1/2/1 (entry 3 g = 1), then flush_req with flush_all = 0, asid = 1 -> busy for 32 cycles, then done pulse. Entries 0 and 1 read v0 = v1 = 0; entries 2 and 3 remain valid. A flush_req during busy has no effect.
- During a flush: write entry 7 on the cycle ptr = 7 -> entry 7 retains the written v0 = 1. Assert rst mid-sweep -> all outputs 0 immediately, with no flush_done.

Source files
------------

// File: rtl/tlb_pipe_if.sv
// Bus bundle between the TLB and the core: two search ports, entry write/read,
// the Wired/Random pair and the flush engine controls.
interface tlb_pipe_if #(
    parameter int TLB_NUM = 32,
    parameter int IDX_W   = $clog2(TLB_NUM),
    parameter int ASID_W  = 8,
    parameter int PFN_W   = 20
);
    logic              s0_req;
    logic [18:0]       s0_vpn2;
    logic              s0_odd_page;
    logic [ASID_W-1:0] s0_asid;
    logic              s0_rvalid;
    logic              s0_found;
    logic              s0_multi;
    logic [IDX_W-1:0]  s0_index;
    logic [PFN_W-1:0]  s0_pfn;
    logic [2:0]        s0_c;
    logic              s0_d;
    logic              s0_v;

    logic              s1_req;
    logic [18:0]       s1_vpn2;
    logic              s1_odd_page;
    logic [ASID_W-1:0] s1_asid;
    logic              s1_rvalid;
    logic              s1_found;
    logic              s1_multi;
    logic [IDX_W-1:0]  s1_index;
    logic [PFN_W-1:0]  s1_pfn;
    logic [2:0]        s1_c;
    logic              s1_d;
    logic              s1_v;

    logic              wr;
    logic [IDX_W-1:0]  w_index;
    logic [18:0]       w_vpn2;
    logic [ASID_W-1:0] w_asid;
    logic              w_g;
    logic [PFN_W-1:0]  w_pfn0;
    logic [2:0]        w_c0;
    logic              w_d0;
    logic              w_v0;
    logic [PFN_W-1:0]  w_pfn1;
    logic [2:0]        w_c1;
    logic              w_d1;
    logic              w_v1;

    logic              r_req;
    logic [IDX_W-1:0]  r_index;
    logic [18:0]       r_vpn2;
    logic [ASID_W-1:0] r_asid;
    logic              r_g;
    logic [PFN_W-1:0]  r_pfn0;
    logic [2:0]        r_c0;
    logic              r_d0;
    logic              r_v0;
    logic [PFN_W-1:0]  r_pfn1;
    logic [2:0]        r_c1;
    logic              r_d1;
    logic              r_v1;

    logic [IDX_W-1:0]  wired;
    logic [IDX_W-1:0]  rand_index;

    logic              flush_req;
    logic              flush_all;
    logic [ASID_W-1:0] flush_asid;
    logic              flush_busy;
    logic              flush_done;

    modport slave (
        input  s0_req, s0_vpn2, s0_odd_page, s0_asid,
        output s0_rvalid, s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_req, s1_vpn2, s1_odd_page, s1_asid,
        output s1_rvalid, s1_found, s1_multi, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  wr, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
               w_pfn1, w_c1, w_d1, w_v1,
        input  r_req, r_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        input  wired,
        output rand_index,
        input  flush_req, flush_all, flush_asid,
        output flush_busy, flush_done
    );

    modport master (
        output s0_req, s0_vpn2, s0_odd_page, s0_asid,
        input  s0_rvalid, s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_req, s1_vpn2, s1_odd_page, s1_asid,
        input  s1_rvalid, s1_found, s1_multi, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output wr, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
               w_pfn1, w_c1, w_d1, w_v1,
        output r_req, r_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
        output wired,
        input  rand_index,
        output flush_req, flush_all, flush_asid,
        input  flush_busy, flush_done
    );
endinterface

// File: rtl/tlb_pipe.sv
// Fully associative dual-search-port TLB with registered lookups, multi-hit
// detection, Wired-aware Random counter and a one-entry-per-cycle flush engine.
module tlb_pipe #(
    parameter int TLB_NUM = 32,
    parameter int IDX_W   = $clog2(TLB_NUM),
    parameter int ASID_W  = 8,
    parameter int PFN_W   = 20
) (
    input logic          clk,
    input logic          rst,
    tlb_pipe_if.slave    bus
);
    typedef struct packed {
        logic [18:0]       vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    localparam entry_t           RESET_ENTRY = '{c0: 3'd3, c1: 3'd3, default: '0};
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TLB_NUM - 1);

    entry_t            r_ent [TLB_NUM];
    entry_t            r_rd;
    entry_t            w_wrEntry;

    logic [1:0]        w_sReq;
    logic [1:0]        w_sOdd;
    logic [18:0]       w_sVpn2 [2];
    logic [ASID_W-1:0] w_sAsid [2];
    logic [TLB_NUM-1:0] w_hit [2];
    logic [1:0]        w_found;
    logic [1:0]        w_multi;
    logic [IDX_W-1:0]  w_idx [2];
    logic [PFN_W-1:0]  w_pfn [2];
    logic [2:0]        w_c [2];
    logic [1:0]        w_d;
    logic [1:0]        w_v;

    logic [1:0]        r_sRvalid;
    logic [1:0]        r_sFound;
    logic [1:0]        r_sMulti;
    logic [IDX_W-1:0]  r_sIdx [2];
    logic [PFN_W-1:0]  r_sPfn [2];
    logic [2:0]        r_sC [2];
    logic [1:0]        r_sD;
    logic [1:0]        r_sV;

    logic [IDX_W-1:0]  r_rand;
    logic [IDX_W-1:0]  w_randNext;

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_ptr;
    logic              r_flushAll;
    logic [ASID_W-1:0] r_flushAsid;
    logic              w_flushHit;
    logic              w_busy;
    logic              w_done;

    assign w_sReq     = {bus.s1_req, bus.s0_req};
    assign w_sOdd     = {bus.s1_odd_page, bus.s0_odd_page};
    assign w_sVpn2[0] = bus.s0_vpn2;
    assign w_sVpn2[1] = bus.s1_vpn2;
    assign w_sAsid[0] = bus.s0_asid;
    assign w_sAsid[1] = bus.s1_asid;

    assign w_wrEntry = {bus.w_vpn2, bus.w_asid, bus.w_g,
                        bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0,
                        bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_hit[p] = '0;
            for (int i = 0; i < TLB_NUM; i++) begin
                w_hit[p][i] = (r_ent[i].vpn2 == w_sVpn2[p]) &&
                              (r_ent[i].g || (r_ent[i].asid == w_sAsid[p]));
            end
        end
    end

    // Descending scan so the lowest-numbered hit wins; hit & (hit-1) is nonzero iff two or more bits set.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_found[p] = 1'b0;
            w_idx[p]   = '0;
            for (int i = TLB_NUM - 1; i >= 0; i--) begin
                if (w_hit[p][i]) begin
                    w_found[p] = 1'b1;
                    w_idx[p]   = IDX_W'(i);
                end
            end
            w_multi[p] = |(w_hit[p] & (w_hit[p] - TLB_NUM'(1)));
            w_pfn[p]   = '0;
            w_c[p]     = '0;
            w_d[p]     = 1'b0;
            w_v[p]     = 1'b0;
            if (w_found[p]) begin
                w_pfn[p] = w_sOdd[p] ? r_ent[w_idx[p]].pfn1 : r_ent[w_idx[p]].pfn0;
                w_c[p]   = w_sOdd[p] ? r_ent[w_idx[p]].c1   : r_ent[w_idx[p]].c0;
                w_d[p]   = w_sOdd[p] ? r_ent[w_idx[p]].d1   : r_ent[w_idx[p]].d0;
                w_v[p]   = w_sOdd[p] ? r_ent[w_idx[p]].v1   : r_ent[w_idx[p]].v0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sRvalid <= '0;
            r_sFound  <= '0;
            r_sMulti  <= '0;
            r_sD      <= '0;
            r_sV      <= '0;
            for (int p = 0; p < 2; p++) begin
                r_sIdx[p] <= '0;
                r_sPfn[p] <= '0;
                r_sC[p]   <= '0;
            end
        end else begin
            r_sRvalid <= w_sReq;
            for (int p = 0; p < 2; p++) begin
                if (w_sReq[p]) begin
                    r_sFound[p] <= w_found[p];
                    r_sMulti[p] <= w_multi[p];
                    r_sIdx[p]   <= w_idx[p];
                    r_sPfn[p]   <= w_pfn[p];
                    r_sC[p]     <= w_c[p];
                    r_sD[p]     <= w_d[p];
                    r_sV[p]     <= w_v[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= '0;
        end else if (bus.r_req) begin
            r_rd <= r_ent[bus.r_index];
        end
    end

    // The write is issued after the flush clear so it takes precedence on the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLB_NUM; i++) begin
                r_ent[i] <= RESET_ENTRY;
            end
        end else begin
            if (r_state == ST_SWEEP && w_flushHit) begin
                r_ent[r_ptr].v0 <= 1'b0;
                r_ent[r_ptr].v1 <= 1'b0;
            end
            if (bus.wr) begin
                r_ent[bus.w_index] <= w_wrEntry;
            end
        end
    end

    always_comb begin
        w_randNext = r_rand - IDX_W'(1);
        if (bus.wired >= LAST_IDX || r_rand <= bus.wired) begin
            w_randNext = LAST_IDX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rand <= LAST_IDX;
        end else begin
            r_rand <= w_randNext;
        end
    end

    assign w_flushHit = r_flushAll ||
                        ((r_ent[r_ptr].asid == r_flushAsid) && !r_ent[r_ptr].g);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    w_nextState = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                w_busy = 1'b1;
                if (r_ptr == LAST_IDX) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_flushAll  <= 1'b0;
            r_flushAsid <= '0;
        end else if (r_state == ST_IDLE && bus.flush_req) begin
            r_ptr       <= '0;
            r_flushAll  <= bus.flush_all;
            r_flushAsid <= bus.flush_asid;
        end else if (r_state == ST_SWEEP) begin
            r_ptr <= r_ptr + IDX_W'(1);
        end
    end

    assign bus.s0_rvalid  = r_sRvalid[0];
    assign bus.s0_found   = r_sFound[0];
    assign bus.s0_multi   = r_sMulti[0];
    assign bus.s0_index   = r_sIdx[0];
    assign bus.s0_pfn     = r_sPfn[0];
    assign bus.s0_c       = r_sC[0];
    assign bus.s0_d       = r_sD[0];
    assign bus.s0_v       = r_sV[0];
    assign bus.s1_rvalid  = r_sRvalid[1];
    assign bus.s1_found   = r_sFound[1];
    assign bus.s1_multi   = r_sMulti[1];
    assign bus.s1_index   = r_sIdx[1];
    assign bus.s1_pfn     = r_sPfn[1];
    assign bus.s1_c       = r_sC[1];
    assign bus.s1_d       = r_sD[1];
    assign bus.s1_v       = r_sV[1];

    assign bus.r_vpn2     = r_rd.vpn2;
    assign bus.r_asid     = r_rd.asid;
    assign bus.r_g        = r_rd.g;
    assign bus.r_pfn0     = r_rd.pfn0;
    assign bus.r_c0       = r_rd.c0;
    assign bus.r_d0       = r_rd.d0;
    assign bus.r_v0       = r_rd.v0;
    assign bus.r_pfn1     = r_rd.pfn1;
    assign bus.r_c1       = r_rd.c1;
    assign bus.r_d1       = r_rd.d1;
    assign bus.r_v1       = r_rd.v1;

    assign bus.rand_index = r_rand;
    assign bus.flush_busy = w_busy;
    assign bus.flush_done = w_done;
endmodule

// File: tb/tb_tlb_pipe.sv
// Directed bench for tlb_pipe: search, multi-hit, global match, Random counter,
// ASID/all flush, write-during-flush and reset mid-flush.
module tb_tlb_pipe;
    localparam int TLB_NUM = 32;
    localparam int IDX_W   = 5;
    localparam int ASID_W  = 8;
    localparam int PFN_W   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tlb_pipe_if #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W), .ASID_W(ASID_W), .PFN_W(PFN_W)) bus ();

    tlb_pipe #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W), .ASID_W(ASID_W), .PFN_W(PFN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                            input logic g, input logic [19:0] pfn0, input logic [2:0] c0, input logic v0,
                            input logic [19:0] pfn1, input logic [2:0] c1, input logic v1);
        bus.wr = 1'b1;   bus.w_index = idx; bus.w_vpn2 = vpn2; bus.w_asid = asid; bus.w_g = g;
        bus.w_pfn0 = pfn0; bus.w_c0 = c0; bus.w_d0 = 1'b1; bus.w_v0 = v0;
        bus.w_pfn1 = pfn1; bus.w_c1 = c1; bus.w_d1 = 1'b1; bus.w_v1 = v1;
        step();
        bus.wr = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] idx);
        bus.r_req = 1'b1; bus.r_index = idx;
        step();
        bus.r_req = 1'b0;
    endtask

    task automatic search0(input logic [18:0] vpn2, input logic [7:0] asid, input logic odd);
        bus.s0_req = 1'b1; bus.s0_vpn2 = vpn2; bus.s0_asid = asid; bus.s0_odd_page = odd;
        step();
        bus.s0_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.s0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_s0_rvalid got %0h want 0", bus.s0_rvalid); end
        checks++; if (bus.s1_found !== 1'b0) begin errors++; $display("[TB] FAIL rst_s1_found got %0h want 0", bus.s1_found); end
        checks++; if (bus.r_c0 !== 3'd0) begin errors++; $display("[TB] FAIL rst_r_c0 got %0h want 0", bus.r_c0); end
        checks++; if (bus.rand_index !== 5'd31) begin errors++; $display("[TB] FAIL rst_rand got %0d want 31", bus.rand_index); end
        checks++; if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush got busy %0h done %0h want 0 0", bus.flush_busy, bus.flush_done); end
        rst = 1'b0;
        do_read(5'd0);
        checks++; if (bus.r_c0 !== 3'd3 || bus.r_c1 !== 3'd3) begin errors++; $display("[TB] FAIL rst_entry_c got %0h/%0h want 3/3", bus.r_c0, bus.r_c1); end
        checks++; if (bus.r_v0 !== 1'b0 || bus.r_vpn2 !== 19'h0) begin errors++; $display("[TB] FAIL rst_entry_v got v0 %0h vpn2 %0h want 0 0", bus.r_v0, bus.r_vpn2); end
    endtask

    task automatic test_random();
        logic [4:0] exp;
        rst = 1'b1; bus.wired = 5'd30;
        step();
        rst = 1'b0;
        checks++; if (bus.rand_index !== 5'd31) begin errors++; $display("[TB] FAIL rand_start got %0d want 31", bus.rand_index); end
        for (int k = 0; k < 4; k++) begin
            step();
            exp = (k % 2 == 0) ? 5'd30 : 5'd31;
            checks++; if (bus.rand_index !== exp) begin errors++; $display("[TB] FAIL rand_wired30 step %0d got %0d want %0d", k, bus.rand_index, exp); end
        end
        bus.wired = 5'd0;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp = (k <= 31) ? 5'(31 - k) : 5'd31;
            checks++; if (bus.rand_index !== exp) begin errors++; $display("[TB] FAIL rand_wired0 step %0d got %0d want %0d", k, bus.rand_index, exp); end
        end
        bus.wired = 5'd31;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.rand_index !== 5'd31) begin errors++; $display("[TB] FAIL rand_wired31 step %0d got %0d want 31", k, bus.rand_index); end
        end
        bus.wired = 5'd0;
    endtask

    task automatic test_search();
        do_write(5'd5, 19'h12345, 8'd3, 1'b0, 20'hAAAAA, 3'd2, 1'b1, 20'hBBBBB, 3'd5, 1'b0);
        search0(19'h12345, 8'd3, 1'b0);
        checks++; if (bus.s0_rvalid !== 1'b1 || bus.s0_found !== 1'b1) begin errors++; $display("[TB] FAIL even_hit got rvalid %0h found %0h want 1 1", bus.s0_rvalid, bus.s0_found); end
        checks++; if (bus.s0_index !== 5'd5 || bus.s0_multi !== 1'b0) begin errors++; $display("[TB] FAIL even_index got %0d multi %0h want 5 0", bus.s0_index, bus.s0_multi); end
        checks++; if (bus.s0_pfn !== 20'hAAAAA || bus.s0_v !== 1'b1 || bus.s0_c !== 3'd2) begin errors++; $display("[TB] FAIL even_fields got pfn %0h v %0h c %0h want aaaaa 1 2", bus.s0_pfn, bus.s0_v, bus.s0_c); end
        search0(19'h12345, 8'd3, 1'b1);
        checks++; if (bus.s0_pfn !== 20'hBBBBB || bus.s0_v !== 1'b0 || bus.s0_c !== 3'd5) begin errors++; $display("[TB] FAIL odd_fields got pfn %0h v %0h c %0h want bbbbb 0 5", bus.s0_pfn, bus.s0_v, bus.s0_c); end
        step();
        checks++; if (bus.s0_rvalid !== 1'b0 || bus.s0_pfn !== 20'hBBBBB) begin errors++; $display("[TB] FAIL search_hold got rvalid %0h pfn %0h want 0 bbbbb", bus.s0_rvalid, bus.s0_pfn); end
    endtask

    task automatic test_multi();
        do_write(5'd2, 19'h00ABC, 8'd7, 1'b0, 20'h11111, 3'd1, 1'b1, 20'h22222, 3'd1, 1'b1);
        do_write(5'd9, 19'h00ABC, 8'd7, 1'b0, 20'h99999, 3'd1, 1'b1, 20'h88888, 3'd1, 1'b1);
        bus.s0_req = 1'b1; bus.s0_vpn2 = 19'h00ABC; bus.s0_asid = 8'd7; bus.s0_odd_page = 1'b0;
        bus.s1_req = 1'b1; bus.s1_vpn2 = 19'h00ABC; bus.s1_asid = 8'd7; bus.s1_odd_page = 1'b0;
        step();
        bus.s0_req = 1'b0; bus.s1_req = 1'b0;
        checks++; if (bus.s0_found !== 1'b1 || bus.s0_multi !== 1'b1 || bus.s0_index !== 5'd2) begin errors++; $display("[TB] FAIL multi_s0 got found %0h multi %0h idx %0d want 1 1 2", bus.s0_found, bus.s0_multi, bus.s0_index); end
        checks++; if (bus.s1_found !== 1'b1 || bus.s1_multi !== 1'b1 || bus.s1_index !== 5'd2) begin errors++; $display("[TB] FAIL multi_s1 got found %0h multi %0h idx %0d want 1 1 2", bus.s1_found, bus.s1_multi, bus.s1_index); end
        checks++; if (bus.s1_rvalid !== 1'b1 || bus.s1_pfn !== 20'h11111) begin errors++; $display("[TB] FAIL multi_pfn got rvalid %0h pfn %0h want 1 11111", bus.s1_rvalid, bus.s1_pfn); end
    endtask

    task automatic test_global();
        search0(19'h12345, 8'd4, 1'b0);
        checks++; if (bus.s0_found !== 1'b0 || bus.s0_pfn !== 20'h0 || bus.s0_index !== 5'd0) begin errors++; $display("[TB] FAIL asid_miss got found %0h pfn %0h idx %0d want 0 0 0", bus.s0_found, bus.s0_pfn, bus.s0_index); end
        do_write(5'd5, 19'h12345, 8'd3, 1'b1, 20'hAAAAA, 3'd2, 1'b1, 20'hBBBBB, 3'd5, 1'b0);
        search0(19'h12345, 8'd4, 1'b0);
        checks++; if (bus.s0_found !== 1'b1 || bus.s0_index !== 5'd5) begin errors++; $display("[TB] FAIL global_hit got found %0h idx %0d want 1 5", bus.s0_found, bus.s0_index); end
    endtask

    task automatic test_read_old();
        bus.r_req = 1'b1; bus.r_index = 5'd5;
        do_write(5'd5, 19'h12345, 8'd3, 1'b1, 20'hCCCCC, 3'd2, 1'b1, 20'hBBBBB, 3'd5, 1'b0);
        bus.r_req = 1'b0;
        checks++; if (bus.r_pfn0 !== 20'hAAAAA) begin errors++; $display("[TB] FAIL read_old got %0h want aaaaa", bus.r_pfn0); end
        do_read(5'd5);
        checks++; if (bus.r_pfn0 !== 20'hCCCCC || bus.r_g !== 1'b1) begin errors++; $display("[TB] FAIL read_new got pfn %0h g %0h want ccccc 1", bus.r_pfn0, bus.r_g); end
    endtask

    task automatic test_flush_asid();
        int busyCnt = 0;
        do_write(5'd0, 19'h100, 8'd1, 1'b0, 20'h10000, 3'd3, 1'b1, 20'h10001, 3'd3, 1'b1);
        do_write(5'd1, 19'h101, 8'd1, 1'b0, 20'h11000, 3'd3, 1'b1, 20'h11001, 3'd3, 1'b1);
        do_write(5'd2, 19'h102, 8'd2, 1'b0, 20'h12000, 3'd3, 1'b1, 20'h12001, 3'd3, 1'b1);
        do_write(5'd3, 19'h103, 8'd1, 1'b1, 20'h13000, 3'd3, 1'b1, 20'h13001, 3'd3, 1'b1);
        bus.flush_req = 1'b1; bus.flush_all = 1'b0; bus.flush_asid = 8'd1;
        step();
        bus.flush_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (bus.flush_busy === 1'b1 && bus.flush_done === 1'b0) busyCnt++;
            if (k == 5) begin bus.flush_req = 1'b1; bus.flush_all = 1'b1; end
            step();
            bus.flush_req = 1'b0; bus.flush_all = 1'b0;
        end
        checks++; if (busyCnt != 32) begin errors++; $display("[TB] FAIL flush_busy_cycles got %0d want 32", busyCnt); end
        checks++; if (bus.flush_done !== 1'b1 || bus.flush_busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_done_pulse got done %0h busy %0h want 1 0", bus.flush_done, bus.flush_busy); end
        step();
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_done_width got %0h want 0", bus.flush_done); end
        do_read(5'd0);
        checks++; if (bus.r_v0 !== 1'b0 || bus.r_v1 !== 1'b0) begin errors++; $display("[TB] FAIL flush_e0 got %0h/%0h want 0/0", bus.r_v0, bus.r_v1); end
        do_read(5'd1);
        checks++; if (bus.r_v0 !== 1'b0 || bus.r_v1 !== 1'b0) begin errors++; $display("[TB] FAIL flush_e1 got %0h/%0h want 0/0", bus.r_v0, bus.r_v1); end
        do_read(5'd2);
        checks++; if (bus.r_v0 !== 1'b1 || bus.r_v1 !== 1'b1) begin errors++; $display("[TB] FAIL flush_e2_kept got %0h/%0h want 1/1", bus.r_v0, bus.r_v1); end
        do_read(5'd3);
        checks++; if (bus.r_v0 !== 1'b1 || bus.r_v1 !== 1'b1) begin errors++; $display("[TB] FAIL flush_e3_global got %0h/%0h want 1/1", bus.r_v0, bus.r_v1); end
    endtask

    task automatic test_flush_write();
        bus.flush_req = 1'b1; bus.flush_all = 1'b1;
        step();
        bus.flush_req = 1'b0; bus.flush_all = 1'b0;
        repeat (7) step();
        do_write(5'd7, 19'h777, 8'd9, 1'b0, 20'h77777, 3'd1, 1'b1, 20'h0, 3'd1, 1'b0);
        for (int k = 0; k < 40 && bus.flush_done !== 1'b1; k++) step();
        checks++; if (bus.flush_done !== 1'b1) begin errors++; $display("[TB] FAIL flush_all_timeout got done %0h want 1", bus.flush_done); end
        step();
        do_read(5'd7);
        checks++; if (bus.r_v0 !== 1'b1 || bus.r_pfn0 !== 20'h77777) begin errors++; $display("[TB] FAIL write_wins got v0 %0h pfn0 %0h want 1 77777", bus.r_v0, bus.r_pfn0); end
        do_read(5'd2);
        checks++; if (bus.r_v0 !== 1'b0 || bus.r_v1 !== 1'b0) begin errors++; $display("[TB] FAIL flush_all_e2 got %0h/%0h want 0/0", bus.r_v0, bus.r_v1); end
    endtask

    task automatic test_reset_mid_flush();
        int doneSeen = 0;
        search0(19'h777, 8'd9, 1'b0);
        do_read(5'd7);
        bus.flush_req = 1'b1; bus.flush_all = 1'b1;
        step();
        bus.flush_req = 1'b0; bus.flush_all = 1'b0;
        repeat (10) step();
        checks++; if (bus.flush_busy !== 1'b1 || bus.s0_found !== 1'b1 || bus.r_v0 !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset got busy %0h found %0h rv0 %0h want 1 1 1", bus.flush_busy, bus.s0_found, bus.r_v0); end
        rst = 1'b1;
        #1;
        checks++; if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_flush got busy %0h done %0h want 0 0", bus.flush_busy, bus.flush_done); end
        checks++; if (bus.s0_found !== 1'b0 || bus.s0_pfn !== 20'h0 || bus.s0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_search got found %0h pfn %0h rvalid %0h want 0 0 0", bus.s0_found, bus.s0_pfn, bus.s0_rvalid); end
        checks++; if (bus.r_v0 !== 1'b0 || bus.r_pfn0 !== 20'h0 || bus.rand_index !== 5'd31) begin errors++; $display("[TB] FAIL mid_rst_read got v0 %0h pfn0 %0h rand %0d want 0 0 31", bus.r_v0, bus.r_pfn0, bus.rand_index); end
        repeat (2) step();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.flush_done !== 1'b0 || bus.flush_busy !== 1'b0) doneSeen++;
            step();
        end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL no_done_after_rst got %0d active cycles want 0", doneSeen); end
    endtask

    initial begin
        bus.s0_req = 1'b0; bus.s0_vpn2 = '0; bus.s0_odd_page = 1'b0; bus.s0_asid = '0;
        bus.s1_req = 1'b0; bus.s1_vpn2 = '0; bus.s1_odd_page = 1'b0; bus.s1_asid = '0;
        bus.wr = 1'b0; bus.w_index = '0; bus.w_vpn2 = '0; bus.w_asid = '0; bus.w_g = 1'b0;
        bus.w_pfn0 = '0; bus.w_c0 = '0; bus.w_d0 = 1'b0; bus.w_v0 = 1'b0;
        bus.w_pfn1 = '0; bus.w_c1 = '0; bus.w_d1 = 1'b0; bus.w_v1 = 1'b0;
        bus.r_req = 1'b0; bus.r_index = '0; bus.wired = '0;
        bus.flush_req = 1'b0; bus.flush_all = 1'b0; bus.flush_asid = '0;
        test_reset();
        test_random();
        test_search();
        test_multi();
        test_global();
        test_read_old();
        test_flush_asid();
        test_flush_write();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
